// File: rtl/idct_pkg.sv
// Shared constants and the transpose address mapping for the 8x8 IDCT transpose buffer.
package idct_pkg;

    localparam int DATA_W    = 32;
    localparam int BLK_LOG2  = 3;
    localparam int IDX_W     = 2 * BLK_LOG2;
    localparam int BLK_WORDS = 1 << IDX_W;

    // Column-major read index -> row-major storage address (row = low bits, col = high bits).
    function automatic logic [IDX_W-1:0] transpose_addr(input logic [IDX_W-1:0] idx);
        return {idx[BLK_LOG2-1:0], idx[IDX_W-1:BLK_LOG2]};
    endfunction

endpackage

// File: rtl/idct_tp_bank.sv
// One 64-word block store: synchronous write, combinational read.
module idct_tp_bank
    import idct_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [BLK_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/idct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: row-major words in, column-major words out at 1 word/cycle.
module idct_transpose_buffer #(
    parameter int DATA_W = idct_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    import idct_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_WORDS - 1);

    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  rd_addr;
    logic              accept;
    logic              fetch;
    logic [DATA_W-1:0] bank_rdata [2];

    // Handshake: a word moves when valid && ready at a rising edge; out_data is held while out_valid && !out_ready.
    assign in_ready = !full[wr_bank];
    assign accept   = in_valid && in_ready;
    assign fetch    = full[rd_bank] && (!out_valid || out_ready);
    assign rd_addr  = transpose_addr(rd_idx);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        idct_tp_bank #(
            .WIDTH(DATA_W)
        ) u_bank (
            .clk   (clk),
            .we    (accept && (wr_bank == 1'(b))),
            .waddr (wr_idx),
            .wdata (in_data),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            wr_idx    <= '0;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                wr_idx <= wr_idx + 1'b1;
                if (wr_idx == LAST_IDX) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                end
            end
            // Write only touches a non-full bank and read only a full one, so the two full updates never collide.
            if (fetch) begin
                out_data  <= bank_rdata[rd_bank];
                out_valid <= 1'b1;
                out_last  <= (rd_idx == LAST_IDX);
                rd_idx    <= rd_idx + 1'b1;
                if (rd_idx == LAST_IDX) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_idct_transpose_buffer.sv
// Bench for idct_transpose_buffer: scenario table plus hand-written reset and backpressure sequences.
module tb_idct_transpose_buffer;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    idct_transpose_buffer #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W:0] exp_q[$];
    int checks       = 0;
    int failures     = 0;
    int words_out    = 0;
    int stall_cycles = 0;
    int valid_cycles = 0;
    int cyc          = 0;
    int first_v      = -1;
    int last_v       = -1;
    int rdy_pct      = 100;
    bit abort_blk    = 1'b0;

    bit           hold_pend = 1'b0;
    logic [W-1:0] hold_data;
    logic         hold_last;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Ready driver: out_ready changes just after each rising edge.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [W:0] exp;
        cyc++;
        if (!rst) begin
            if (hold_pend) begin
                check(out_valid == 1'b1, "hold_valid", 64'(out_valid), 64'd1);
                check(out_data == hold_data && out_last == hold_last, "hold_data",
                      {31'd0, out_last, out_data}, {31'd0, hold_last, hold_data});
            end
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "extra_word", {31'd0, out_last, out_data}, 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check({out_last, out_data} == exp, "word", {31'd0, out_last, out_data}, {31'd0, exp});
                    words_out++;
                    if (first_v < 0) first_v = cyc;
                    last_v = cyc;
                end
            end
            if (in_valid && !in_ready) stall_cycles++;
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end else begin
            hold_pend = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left just after a rising edge; leaves in_valid as last driven.
    task automatic send_block(input int base, input int nwords, input int vld_pct, input bit rnd);
        logic [W-1:0] vals [64];
        bit take;
        int n;
        for (int i = 0; i < 64; i++) vals[i] = rnd ? W'($urandom) : W'(base + i);
        for (int k = 0; k < 64; k++) begin
            // k-th output (column-major): row = k % 8, col = k / 8, stored at row*8+col.
            exp_q.push_back({(k == 63), vals[(k % 8) * 8 + (k / 8)]});
        end
        abort_blk = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            while ($urandom_range(99) >= vld_pct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = vals[i];
            n = 0;
            forever begin
                @(negedge clk);
                take = in_ready;
                @(posedge clk);
                #1;
                if (take) break;
                n++;
                if (n > 5000) begin
                    check(1'b0, "in_ready_timeout", 64'(n), 64'd5000);
                    abort_blk = 1'b1;
                    break;
                end
            end
            if (abort_blk) break;
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic clear_stats();
        words_out    = 0;
        stall_cycles = 0;
        first_v      = -1;
        last_v       = -1;
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int base;
        int nblk;
        int vld_pct;
        int rdy_pct;
        bit rnd;
        bit chk_latency;
        bit chk_contig;
        int exp_words;
    } scen_t;

    scen_t tbl [3];

    initial begin
        int vc0;
        tbl[0] = '{base: 0, nblk: 1,  vld_pct: 100, rdy_pct: 100, rnd: 1'b0, chk_latency: 1'b1, chk_contig: 1'b0, exp_words: 64};
        tbl[1] = '{base: 0, nblk: 3,  vld_pct: 100, rdy_pct: 100, rnd: 1'b0, chk_latency: 1'b0, chk_contig: 1'b1, exp_words: 192};
        tbl[2] = '{base: 0, nblk: 10, vld_pct: 50,  rdy_pct: 50,  rnd: 1'b1, chk_latency: 1'b0, chk_contig: 1'b0, exp_words: 640};

        in_valid = 1'b0;
        in_data  = '0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        check(out_data == '0, "rst_out_data", 64'(out_data), 64'd0);
        check(out_last == 1'b0, "rst_out_last", 64'(out_last), 64'd0);
        check(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);

        for (int s = 0; s < 3; s++) begin
            rdy_pct = tbl[s].rdy_pct;
            @(posedge clk);
            #1;
            clear_stats();
            for (int k = 0; k < tbl[s].nblk; k++) begin
                send_block(tbl[s].base + k * 100, 64, tbl[s].vld_pct, tbl[s].rnd);
                if (tbl[s].chk_latency && k == tbl[s].nblk - 1) begin
                    in_valid = 1'b0;
                    check(out_valid == 1'b0, "latency_t1", 64'(out_valid), 64'd0);
                    @(posedge clk);
                    #1;
                    check(out_valid == 1'b1, "latency_t2", 64'(out_valid), 64'd1);
                end
            end
            in_valid = 1'b0;
            wait_drain(4000);
            check(words_out == tbl[s].exp_words, "word_count", 64'(words_out), 64'(tbl[s].exp_words));
            if (tbl[s].chk_contig) begin
                check(last_v - first_v + 1 == tbl[s].exp_words, "contiguous",
                      64'(last_v - first_v + 1), 64'(tbl[s].exp_words));
                check(stall_cycles == 0, "no_in_stall", 64'(stall_cycles), 64'd0);
            end
        end

        // Backpressure: first word held, both banks fill, then release.
        rdy_pct = 0;
        @(posedge clk);
        #1;
        clear_stats();
        send_block(0, 64, 100, 1'b0);
        send_block(64, 64, 100, 1'b0);
        in_valid = 1'b0;
        check(in_ready == 1'b0, "bp_in_ready", 64'(in_ready), 64'd0);
        check(out_valid == 1'b1, "bp_out_valid", 64'(out_valid), 64'd1);
        check(out_data == '0, "bp_out_data", 64'(out_data), 64'd0);
        fork
            send_block(128, 64, 100, 1'b0);
            begin
                repeat (20) @(posedge clk);
                #1;
                check(in_ready == 1'b0, "bp_in_ready_held", 64'(in_ready), 64'd0);
                check(out_data == '0, "bp_out_data_held", 64'(out_data), 64'd0);
                rdy_pct = 100;
            end
        join
        in_valid = 1'b0;
        wait_drain(1000);
        check(words_out == 192, "bp_word_count", 64'(words_out), 64'd192);

        // Reset after 30 words of a block.
        send_block(1000, 30, 100, 1'b0);
        pulse_reset();
        check(out_valid == 1'b0, "mid_rst_out_valid", 64'(out_valid), 64'd0);
        check(out_data == '0, "mid_rst_out_data", 64'(out_data), 64'd0);
        check(in_ready == 1'b1, "mid_rst_in_ready", 64'(in_ready), 64'd1);
        clear_stats();
        send_block(0, 64, 100, 1'b0);
        in_valid = 1'b0;
        wait_drain(500);
        check(words_out == 64, "mid_rst_words", 64'(words_out), 64'd64);

        // Reset while one bank drains and the other is full.
        rdy_pct = 0;
        @(posedge clk);
        #1;
        send_block(2000, 64, 100, 1'b0);
        send_block(3000, 64, 100, 1'b0);
        in_valid = 1'b0;
        rdy_pct  = 100;
        repeat (10) @(posedge clk);
        #1;
        pulse_reset();
        check(out_valid == 1'b0, "drain_rst_out_valid", 64'(out_valid), 64'd0);
        check(out_last == 1'b0, "drain_rst_out_last", 64'(out_last), 64'd0);
        check(in_ready == 1'b1, "drain_rst_in_ready", 64'(in_ready), 64'd1);
        vc0 = valid_cycles;
        repeat (100) @(posedge clk);
        #1;
        check(valid_cycles == vc0, "drain_rst_quiet", 64'(valid_cycles - vc0), 64'd0);
        clear_stats();
        send_block(4000, 64, 100, 1'b0);
        in_valid = 1'b0;
        wait_drain(500);
        check(words_out == 64, "drain_rst_words", 64'(words_out), 64'd64);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idct_transpose_buffer.md
Name: idct_transpose_buffer

Overview:
- Ping-pong 8x8 transpose memory between the row-pass and column-pass 1-D IDCT stages.
- Accepts 64 32-bit row-pass results per block in row-major order.
- Emits the same 64 words in column-major order to the column pass, through a registered output word.
- Two banks allow one block to be written while the previous block drains, giving sustained 1 word/cycle throughput.

Parameters:
- DATA_W, 32, width of each coefficient word.
- BLK_LOG2, 3, log2 of the block edge. This block is fixed at 3 (8x8, 64 words); other values are unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  buffer can accept a word this cycle
- in_data  in  DATA_W  row-major coefficient
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  DATA_W  column-major coefficient (registered)
- out_last  out  1  high with the 64th word of each block

Behaviour:
- Storage:
  - bank[0..1], 64 x DATA_W each.
  - Per-bank full flag.
  - wr_bank, wr_idx[5:0]; rd_bank, rd_idx[5:0].
- Reset (rst=1 at posedge): applies even mid-block; partial blocks are discarded.
  - Both full flags cleared.
  - wr_bank=0, wr_idx=0, rd_bank=0, rd_idx=0.
  - out_valid=0, out_data=0, out_last=0.
  - in_ready is combinational and equals 1 after reset.
- Write side:
  - in_ready = !full[wr_bank].
  - Accept when in_valid && in_ready: bank[wr_bank][wr_idx] <= in_data, wr_idx++.
  - When wr_idx==63 is accepted: full[wr_bank]<=1, wr_bank toggles, wr_idx wraps to 0.
- Read side:
  - fetch = full[rd_bank] && (!out_valid || out_ready).
  - On fetch:
    - out_data <= bank[rd_bank][{rd_idx[2:0], rd_idx[5:3]}], i.e. row = rd_idx[2:0], col = rd_idx[5:3], address = row*8+col.
    - out_valid<=1, out_last<=(rd_idx==63), rd_idx++.
  - On fetch with rd_idx==63: full[rd_bank]<=0, rd_bank toggles, rd_idx wraps to 0.
  - If out_valid && out_ready && !fetch: out_valid<=0, out_last<=0. out_data holds its last value.
  - While out_valid && !out_ready: out_data, out_valid and out_last are held stable.
- Latency and throughput:
  - 64th word of a block accepted at cycle T → bank full at T+1 → fetch of index 0 at T+1 → out_valid=1 at T+2.
  - The last fetch is at T+64; that bank's full flag clears at the same edge, so it is writable at T+65.
  - With continuous in_valid=1 and out_ready=1, in_ready never deasserts and out_valid has no bubbles after the first block.
- Simultaneous events:
  - Setting full[x] from the write side and clearing full[y] from the read side in the same cycle are independent; x≠y always holds.
  - Both banks full → in_ready=0 until the draining bank's last fetch.
- Write and read of the same bank never coincide: a bank is written only while !full and read only while full.

Decomposition:
- Package idct_pkg: DATA_W, BLK_WORDS=64, IDX_W=6, and the function transpose_addr(idx) → {idx[2:0], idx[5:3]}.
- Sub-module idct_tp_bank: 64 x DATA_W memory with synchronous write and combinational read, instantiated twice.
- Flags, pointers and the output register live in the top module.

Test Plan:
- Single block, in_data=0..63, out_ready=1 → out_data sequence 0,8,16,…,56,1,9,…,63; out_last=1 only on the final word (63); first out_valid 2 cycles after the 64th accept.
- Three back-to-back blocks (values k*100+i), in_valid=1 and out_ready=1 throughout → in_ready stays 1; outputs contiguous, 192 words, each block transposed.
- out_ready held 0 after the first output word → out_data stays at 0 with out_valid=1 and does not change; in_ready drops after the second block fills (128 words accepted); releasing out_ready resumes output in order.
- Random in_valid/out_ready gaps (50% each) over 10 blocks → scoreboard transpose matches exactly; no lost or duplicated words.
- rst asserted after 30 words of a block → next cycle out_valid=0, out_data=0, in_ready=1; a fresh block 0..63 then transposes correctly with no stale data.
- rst asserted while bank 0 is draining and bank 1 is full → both flags clear; no further out_valid until 64 new words are written.
